// File: rtl/span_rasterizer.sv
`timescale 1ns/1ps
// Horizontal-span rasterizer: expands one span command into one 96-bit pixel word per column,
// pushed into the rasterizer-to-framebuffer-writer FIFO. Optional clipping via `SPAN_CLIP_EN.
module span_rasterizer #(
  parameter int LINE_LEN          = 9,
  parameter int COL_LEN           = 10,
  parameter int RAST_FBW_FIFO_LEN = 96,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480
) (
  input  logic                           PLB_clk,
  input  logic                           reset,
  input  logic                           span_valid,
  output logic                           span_ready,
  input  logic [0:LINE_LEN-1]            span_line,
  input  logic [0:COL_LEN-1]             span_col0,
  input  logic [0:COL_LEN-1]             span_col1,
  input  logic [0:31]                    span_color,
  input  logic [0:31]                    span_z0,
  input  logic [0:31]                    span_dz,
  output logic                           fifo_wr_en,
  output logic [0:RAST_FBW_FIFO_LEN-1]   fifo_wr_data,
  input  logic                           fifo_full,
  output logic                           busy,
  output logic [0:31]                    pixel_count
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [LINE_LEN-1:0] line_q, line_d;
  logic [COL_LEN-1:0]  cur_col_q, cur_col_d;
  logic [COL_LEN-1:0]  col1_q, col1_d;
  logic [31:0]         color_q, color_d;
  logic [31:0]         cur_z_q, cur_z_d;
  logic [31:0]         dz_q, dz_d;
  logic [31:0]         count_q, count_d;

  logic                drop;
  logic [COL_LEN-1:0]  col1_eff;
  logic                push;

`ifdef SPAN_CLIP_EN
  // Off-screen spans are dropped like empty ones; the right edge is clamped.
  assign drop     = (span_col1 < span_col0) || (32'(span_line) >= SCREEN_H) ||
                    (32'(span_col0) >= SCREEN_W);
  assign col1_eff = (32'(span_col1) >= SCREEN_W) ? COL_LEN'(SCREEN_W - 1) : span_col1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{SCREEN_W, SCREEN_H};
  assign drop       = span_col1 < span_col0;
  assign col1_eff   = span_col1;
`endif

  assign push = (state_q == EMIT) && !fifo_full;

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    state_d   = state_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    line_d    = line_q;
    cur_col_d = cur_col_q;
    col1_d    = col1_q;
    color_d   = color_q;
    cur_z_d   = cur_z_q;
    dz_d      = dz_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (span_valid) begin
          line_d    = span_line;
          cur_col_d = span_col0;
          col1_d    = col1_eff;
          color_d   = span_color;
          cur_z_d   = span_z0;
          dz_d      = span_dz;
          if (!drop) begin
            state_d = EMIT;
            ready_d = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (push) begin
          cur_col_d = cur_col_q + COL_LEN'(1);
          cur_z_d   = cur_z_q + dz_q;
          count_d   = count_q + 32'd1;
          // Equality termination keeps a full 2^COL_LEN span from wrapping the counter.
          if (cur_col_q == col1_q) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge PLB_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      line_q    <= '0;
      cur_col_q <= '0;
      col1_q    <= '0;
      color_q   <= '0;
      cur_z_q   <= '0;
      dz_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      line_q    <= line_d;
      cur_col_q <= cur_col_d;
      col1_q    <= col1_d;
      color_q   <= color_d;
      cur_z_q   <= cur_z_d;
      dz_q      <= dz_d;
      count_q   <= count_d;
    end
  end

  assign span_ready   = ready_q;
  assign busy         = busy_q;
  assign pixel_count  = count_q;
  assign fifo_wr_en   = push;
  assign fifo_wr_data = {16'(line_q), 16'(cur_col_q), color_q, cur_z_q};

endmodule

// File: tb/tb_span_rasterizer.sv
`timescale 1ns/1ps
// Scoreboard bench for span_rasterizer: stimulus pushes hand-computed words, a monitor pops
// and compares on every FIFO push. Define SPAN_CLIP_EN to also exercise clipping.
module tb_span_rasterizer;

  localparam int LINE_LEN = 9;
  localparam int COL_LEN  = 10;

  logic                PLB_clk = 1'b0;
  logic                reset;
  logic                span_valid;
  logic                span_ready;
  logic [0:LINE_LEN-1] span_line;
  logic [0:COL_LEN-1]  span_col0, span_col1;
  logic [0:31]         span_color, span_z0, span_dz;
  logic                fifo_wr_en;
  logic [0:95]         fifo_wr_data;
  logic                fifo_full;
  logic                busy;
  logic [0:31]         pixel_count;

  span_rasterizer #(
    .LINE_LEN(LINE_LEN), .COL_LEN(COL_LEN), .RAST_FBW_FIFO_LEN(96),
    .SCREEN_W(640), .SCREEN_H(480)
  ) dut (
    .PLB_clk(PLB_clk), .reset(reset),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_line(span_line), .span_col0(span_col0), .span_col1(span_col1),
    .span_color(span_color), .span_z0(span_z0), .span_dz(span_dz),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .busy(busy), .pixel_count(pixel_count)
  );

  always #5 PLB_clk = ~PLB_clk;

  logic [95:0] exp_q[$];
  int          push_cyc[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge PLB_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int line, input int col, input logic [31:0] color,
                          input logic [31:0] z);
    exp_q.push_back({16'(line), 16'(col), color, z});
  endtask

  // Monitor: compares every pushed word against the scoreboard head.
  always @(negedge PLB_clk) begin
    if (!reset) begin
      if (fifo_full) check("no_push_when_full", 96'(fifo_wr_en), 96'(0));
      if (fifo_wr_en) begin
        push_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_push: got word %h with empty scoreboard", fifo_wr_data);
        end else begin
          check("pixel_word", fifo_wr_data, exp_q.pop_front());
        end
      end else if (busy && fifo_full && exp_q.size() > 0) begin
        check("stall_data_stable", fifo_wr_data, exp_q[0]);
      end
    end
  end

  // Presents a span at posedge+1 and returns just after the accepting edge (+1).
  task automatic send_span(input int line, input int c0, input int c1, input logic [31:0] color,
                           input logic [31:0] z0, input logic [31:0] dz, input bit hold);
    bit accepted = 1'b0;
    @(posedge PLB_clk);
    #1;
    span_valid = 1'b1;
    span_line  = LINE_LEN'(line);
    span_col0  = COL_LEN'(c0);
    span_col1  = COL_LEN'(c1);
    span_color = color;
    span_z0    = z0;
    span_dz    = dz;
    for (int i = 0; i < 300; i++) begin
      @(negedge PLB_clk);
      if (span_ready) begin
        @(posedge PLB_clk);
        accepted = 1'b1;
        break;
      end
    end
    #1;
    if (!hold) span_valid = 1'b0;
    if (!accepted) check("span_accept_timeout", 96'(span_ready), 96'(1));
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PLB_clk);
      if (exp_q.size() == 0 && span_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout_scoreboard_left", 96'(exp_q.size()), 96'(0));
  endtask

  task automatic pulse_reset();
    @(posedge PLB_clk);
    #1 reset = 1'b1;
    @(posedge PLB_clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1; span_valid = 1'b0; fifo_full = 1'b0;
    span_line = '0; span_col0 = '0; span_col1 = '0;
    span_color = '0; span_z0 = '0; span_dz = '0;

    // Reset state.
    repeat (2) @(negedge PLB_clk);
    check("rst_span_ready", 96'(span_ready), 96'(1));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_fifo_wr_en", 96'(fifo_wr_en), 96'(0));
    check("rst_pixel_count", 96'(pixel_count), 96'(0));
    check("rst_fifo_wr_data", 96'(fifo_wr_data), 96'(0));
    @(posedge PLB_clk);
    #1 reset = 1'b0;

    // Basic span: four pushes on consecutive cycles.
    push_exp(5, 10, 32'hFF00FF00, 100);
    push_exp(5, 11, 32'hFF00FF00, 102);
    push_exp(5, 12, 32'hFF00FF00, 104);
    push_exp(5, 13, 32'hFF00FF00, 106);
    send_span(5, 10, 13, 32'hFF00FF00, 100, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PLB_clk);
      check("basic_push_each_cycle", 96'(fifo_wr_en), 96'(1));
      check("basic_busy", 96'(busy), 96'(1));
    end
    @(negedge PLB_clk);
    check("basic_ready_after_last", 96'(span_ready), 96'(1));
    check("basic_no_extra_push", 96'(fifo_wr_en), 96'(0));
    check("basic_pixel_count", 96'(pixel_count), 96'(4));

    // Backpressure: full during EMIT cycles 2..4.
    n0 = push_cyc.size();
    push_exp(5, 10, 32'hFF00FF00, 100);
    push_exp(5, 11, 32'hFF00FF00, 102);
    push_exp(5, 12, 32'hFF00FF00, 104);
    push_exp(5, 13, 32'hFF00FF00, 106);
    send_span(5, 10, 13, 32'hFF00FF00, 100, 2, 1'b0);
    @(posedge PLB_clk);
    #1 fifo_full = 1'b1;
    repeat (3) @(posedge PLB_clk);
    #1 fifo_full = 1'b0;
    wait_drain();
    check("bp_push_count", 96'(push_cyc.size() - n0), 96'(4));
    check("bp_stall_gap", 96'(push_cyc[n0+1] - push_cyc[n0]), 96'(4));
    check("bp_resume_back_to_back", 96'(push_cyc[n0+3] - push_cyc[n0+1]), 96'(2));
    check("bp_pixel_count", 96'(pixel_count), 96'(8));

    // Single-pixel span.
    push_exp(0, 7, 32'h00000011, 50);
    send_span(0, 7, 7, 32'h00000011, 50, 1, 1'b0);
    wait_drain();
    check("single_pixel_count", 96'(pixel_count), 96'(9));

    // Empty span: col1 < col0.
    n0 = push_cyc.size();
    send_span(0, 9, 8, 32'h00000022, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PLB_clk);
      check("empty_ready_stays_high", 96'(span_ready), 96'(1));
      check("empty_not_busy", 96'(busy), 96'(0));
    end
    check("empty_no_push", 96'(push_cyc.size() - n0), 96'(0));
    check("empty_pixel_count", 96'(pixel_count), 96'(9));

    // Depth wrap with dz = -1.
    push_exp(1, 0, 32'h12345678, 32'h00000000);
    push_exp(1, 1, 32'h12345678, 32'hFFFFFFFF);
    push_exp(1, 2, 32'h12345678, 32'hFFFFFFFE);
    send_span(1, 0, 2, 32'h12345678, 0, 32'hFFFFFFFF, 1'b0);
    wait_drain();
    check("zwrap_pixel_count", 96'(pixel_count), 96'(12));

    // Reset mid-span after two of six pushes.
    push_exp(3, 20, 32'hCAFEBABE, 1000);
    push_exp(3, 21, 32'hCAFEBABE, 1003);
    send_span(3, 20, 25, 32'hCAFEBABE, 1000, 3, 1'b0);
    repeat (2) @(posedge PLB_clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_wr_en_low", 96'(fifo_wr_en), 96'(0));
    check("midrst_busy_low", 96'(busy), 96'(0));
    check("midrst_pixel_count", 96'(pixel_count), 96'(0));
    check("midrst_ready_high", 96'(span_ready), 96'(1));
    check("midrst_two_pushes_seen", 96'(exp_q.size()), 96'(0));
    exp_q.delete();
    @(posedge PLB_clk);
    #1 reset = 1'b0;
    push_exp(2, 0, 32'hAAAA5555, 5);
    push_exp(2, 1, 32'hAAAA5555, 6);
    send_span(2, 0, 1, 32'hAAAA5555, 5, 1, 1'b0);
    wait_drain();
    check("postrst_pixel_count", 96'(pixel_count), 96'(2));

    // Back-to-back spans with span_valid held high.
    pulse_reset();
    n0 = push_cyc.size();
    push_exp(7, 100, 32'h01020304, 10);
    push_exp(7, 101, 32'h01020304, 20);
    push_exp(7, 102, 32'h01020304, 30);
    push_exp(8, 200, 32'h0A0B0C0D, 1000);
    push_exp(8, 201, 32'h0A0B0C0D, 999);
    push_exp(8, 202, 32'h0A0B0C0D, 998);
    send_span(7, 100, 102, 32'h01020304, 10, 10, 1'b1);
    send_span(8, 200, 202, 32'h0A0B0C0D, 1000, 32'hFFFFFFFF, 1'b0);
    wait_drain();
    check("b2b_push_count", 96'(push_cyc.size() - n0), 96'(6));
    if (push_cyc.size() - n0 == 6) begin
      check("b2b_first_span_contiguous", 96'(push_cyc[n0+2] - push_cyc[n0]), 96'(2));
      check("b2b_one_gap_cycle", 96'(push_cyc[n0+3] - push_cyc[n0+2]), 96'(2));
      check("b2b_second_span_contiguous", 96'(push_cyc[n0+5] - push_cyc[n0+3]), 96'(2));
    end
    check("b2b_pixel_count", 96'(pixel_count), 96'(6));

`ifdef SPAN_CLIP_EN
    // Clipping: right edge clamped, off-screen line/column dropped.
    for (int c = 630; c < 640; c++) push_exp(479, c, 32'h55AA55AA, 32'(c - 630));
    send_span(479, 630, 700, 32'h55AA55AA, 0, 1, 1'b0);
    wait_drain();
    check("clip_pixel_count", 96'(pixel_count), 96'(16));
    n0 = push_cyc.size();
    send_span(480, 0, 5, 32'h1, 0, 1, 1'b0);
    repeat (3) @(negedge PLB_clk);
    check("clip_line480_ready", 96'(span_ready), 96'(1));
    send_span(0, 640, 650, 32'h2, 0, 1, 1'b0);
    repeat (3) @(negedge PLB_clk);
    check("clip_col640_ready", 96'(span_ready), 96'(1));
    check("clip_dropped_no_push", 96'(push_cyc.size() - n0), 96'(0));
    check("clip_dropped_pixel_count", 96'(pixel_count), 96'(16));
`endif

    repeat (4) @(negedge PLB_clk);
    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
